alu_iter_nbit: RTL and testbench

- Parametrised N-bit successor to the 1-bit ALU slice; same four modes (add, sub, compare, AND), same M1/M0 encoding, same F/Cout/N flag meaning.
- Iterative: processes SLICE bits per clock, LSB-first, carrying carry/compare state between slices.
- Start/busy/done handshake; registered result held until next operation.
- Sits between operand registers and the datapath result bus; trades latency for area.

---
 rtl/alu_iter_nbit.sv | 165 ++++++++++++++++
 tb/tb_alu_iter_nbit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_nbit.sv
// alu_iter_nbit: iterative N-bit ALU (add, sub, unsigned compare, AND), SLICE bits per clock, LSB first.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               request, accepted only in IDLE; M1/M0, A, B, Cin are latched with it
//   busy                high while slices are processed
//   done                one-cycle pulse when F/Cout/N(/V) are updated
//   F, Cout, N          result, carry-out (add/sub) or A>B (compare), MSB of F or A<B (compare)
//   V                   signed overflow, only when ALU_OVF_EN is defined
module alu_iter_nbit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M0,
    input  logic             M1,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             N
`ifdef ALU_OVF_EN
    ,
    output logic             V
`endif
);
    localparam int K  = WIDTH / SLICE;
    localparam int IW = $clog2(K + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, f_q, f_d, acc_n;
    logic [1:0] mode_q, mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic cout_q, cout_d, n_q, n_d, busy_q, busy_d, done_q, done_d;
    logic [SLICE-1:0] a_s, b_s, b_x, res;
    logic [SLICE:0] sum;
    logic eq_n, gt_n, lt_n, last;
`ifdef ALU_OVF_EN
    logic v_q, v_d;
`endif
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        f_d     = f_q;
        cout_d  = cout_q;
        n_d     = n_q;
`ifdef ALU_OVF_EN
        v_d     = v_q;
`endif
        a_s  = a_q[SLICE-1:0];
        b_s  = b_q[SLICE-1:0];
        // subtract is add of the inverted operand with the carry seeded to 1
        b_x  = mode_q[0] ? ~b_s : b_s;
        sum  = {1'b0, a_s} + {1'b0, b_x} + {{SLICE{1'b0}}, carry_q};
        res  = (mode_q == 2'b11) ? (a_s & b_s) : sum[SLICE-1:0];
        // result bits enter at the top so after K slices the LSB slice is at bit 0
        acc_n = (acc_q >> SLICE) | (WIDTH'(res) << (WIDTH - SLICE));
        // a later (more significant) differing slice overrides gt/lt
        eq_n = eq_q & (a_s == b_s);
        gt_n = (a_s != b_s) ? (a_s > b_s) : gt_q;
        lt_n = (a_s != b_s) ? (a_s < b_s) : lt_q;
        last = idx_q == IW'(K - 1);
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = A;
                b_d     = B;
                mode_d  = {M1, M0};
                carry_d = M1 ? 1'b0 : (M0 ? 1'b1 : Cin);
                idx_d   = '0;
                acc_d   = '0;
                eq_d    = 1'b1;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
            end
            RUN: begin
                a_d     = a_q >> SLICE;
                b_d     = b_q >> SLICE;
                acc_d   = acc_n;
                carry_d = sum[SLICE];
                eq_d    = eq_n;
                gt_d    = gt_n;
                lt_d    = lt_n;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    f_d     = (mode_q == 2'b10) ? WIDTH'(eq_n) : acc_n;
                    cout_d  = (mode_q == 2'b10) ? gt_n : (mode_q == 2'b11) ? 1'b0 : sum[SLICE];
                    n_d     = (mode_q == 2'b10) ? lt_n : acc_n[WIDTH-1];
`ifdef ALU_OVF_EN
                    // carry into the MSB recovered from the MSB sum bit and its operands
                    v_d     = mode_q[1] ? 1'b0 :
                              (sum[SLICE-1] ^ a_s[SLICE-1] ^ b_x[SLICE-1]) ^ sum[SLICE];
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mode_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_OVF_EN
            v_q     <= v_d;
`endif
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign F    = f_q;
    assign Cout = cout_q;
    assign N    = n_q;
`ifdef ALU_OVF_EN
    assign V    = v_q;
`endif
endmodule

// File: tb/tb_alu_iter_nbit.sv
// tb_alu_iter_nbit: randomized and directed check of alu_iter_nbit at SLICE=1 and SLICE=4 against an arithmetic model.
module tb_alu_iter_nbit;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, M0 = 1'b0, M1 = 1'b0, Cin = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic busy1, done1, c1, n1, busy4, done4, c4, n4;
    logic [W-1:0] f1, f4;
    logic [W-1:0] prev_f = '0;
    int n_chk = 0, n_fail = 0;
`ifdef ALU_OVF_EN
    logic v1, v4;
`endif
    alu_iter_nbit #(.WIDTH(W), .SLICE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .M0(M0), .M1(M1), .A(A), .B(B), .Cin(Cin),
        .busy(busy1), .done(done1), .F(f1), .Cout(c1), .N(n1)
`ifdef ALU_OVF_EN
        , .V(v1)
`endif
    );
    alu_iter_nbit #(.WIDTH(W), .SLICE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .M0(M0), .M1(M1), .A(A), .B(B), .Cin(Cin),
        .busy(busy4), .done(done4), .F(f4), .Cout(c4), .N(n4)
`ifdef ALU_OVF_EN
        , .V(v4)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, output logic [W-1:0] f, output logic c,
                                  output logic n, output logic v);
        logic [W:0] s;
        s = '0;
        v = 1'b0;
        case (md)
            2'b00: s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            2'b01: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            default: s = '0;
        endcase
        f = s[W-1:0];
        c = s[W];
        if (md == 2'b00) v = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
        if (md == 2'b01) v = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
        if (md == 2'b10) begin
            f = W'(a == b);
            c = a > b;
        end
        if (md == 2'b11) begin
            f = a & b;
            c = 1'b0;
        end
        n = (md == 2'b10) ? (a < b) : f[W-1];
    endfunction
    task automatic run_op(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input bit poke);
        logic [W-1:0] ef;
        logic ec, en, ev;
        int l1 = 0, l4 = 0, k1 = 0, k4 = 0, hold = 0;
        model(md, a, b, ci, ef, ec, en, ev);
        @(negedge clk);
        {M1, M0} = md;
        A = a;
        B = b;
        Cin = ci;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        {M1, M0} = 2'($urandom);
        Cin = 1'($urandom);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (poke && cyc == 2) start = 1'b1;
            if (poke && cyc == 3) start = 1'b0;
            @(posedge clk);
            #1;
            if (done1) begin k1++; if (l1 == 0) l1 = cyc; end
            if (done4) begin k4++; if (l4 == 0) l4 = cyc; end
            if (l1 == 0 && f1 !== prev_f) hold++;
            if (l4 == 0 && f4 !== prev_f) hold++;
        end
        check("lat_s1", l1, 8);
        check("lat_s4", l4, 2);
        check("dones_s1", k1, 1);
        check("dones_s4", k4, 1);
        check("hold", hold, 0);
        check("f_s1", f1, ef);
        check("f_s4", f4, ef);
        check("cout_s1", c1, ec);
        check("cout_s4", c4, ec);
        check("n_s1", n1, en);
        check("n_s4", n4, en);
`ifdef ALU_OVF_EN
        check("v_s1", v1, ev);
        check("v_s4", v4, ev);
`endif
        prev_f = ef;
    endtask
    initial begin
        int t1[$], t4[$];
        int k;
        #3 rst_n = 1'b0;
        #4;
        check("rst_busy", {busy1, busy4}, 0);
        check("rst_done", {done1, done4}, 0);
        check("rst_f", {f1, f4}, 0);
        check("rst_flags", {c1, n1, c4, n4}, 0);
        @(negedge clk) rst_n = 1'b1;
        run_op(2'b00, 8'hF0, 8'h20, 1'b0, 0);
        run_op(2'b01, 8'h05, 8'h07, 1'b0, 0);
        run_op(2'b01, 8'h80, 8'h01, 1'b1, 0);
        run_op(2'b10, 8'h81, 8'h7F, 1'b0, 0);
        run_op(2'b10, 8'h3C, 8'h3C, 1'b0, 0);
        run_op(2'b10, 8'h01, 8'h02, 1'b0, 0);
        run_op(2'b11, 8'hCA, 8'hF0, 1'b0, 1);
        run_op(2'b00, 8'hFF, 8'h00, 1'b1, 0);
        for (int i = 0; i < 20; i++)
            run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), i[0]);
        // reset in the middle of an add
        @(negedge clk);
        {M1, M0} = 2'b00;
        A = 8'h55;
        B = 8'h33;
        Cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {busy1, busy4}, 0);
        check("mid_rst_done", {done1, done4}, 0);
        check("mid_rst_f", {f1, f4}, 0);
        @(negedge clk) rst_n = 1'b1;
        k = 0;
        repeat (15) begin
            @(posedge clk);
            #1 k += int'(done1) + int'(done4);
        end
        check("no_done_after_rst", k, 0);
        prev_f = '0;
        run_op(2'b00, 8'h01, 8'h01, 1'b0, 0);
        // start held high: each instance reissues every K+2 cycles
        @(negedge clk);
        {M1, M0} = 2'b00;
        A = 8'h11;
        B = 8'h22;
        Cin = 1'b0;
        start = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(posedge clk);
            #1;
            if (done1) t1.push_back(cyc);
            if (done4) t4.push_back(cyc);
            if (t1.size() == 0 && f1 !== prev_f) k++;
        end
        start = 1'b0;
        check("bb_hold", k, 0);
        check("bb_cnt_s1", t1.size(), 4);
        check("bb_cnt_s4", t4.size() >= 3, 1);
        if (t1.size() >= 3 && t4.size() >= 3) begin
            check("bb_first_s1", t1[0], 8);
            check("bb_int_s1", t1[2] - t1[1], 10);
            check("bb_first_s4", t4[0], 2);
            check("bb_int_s4", t4[2] - t4[1], 4);
        end
        check("bb_f_s1", f1, 8'h33);
        check("bb_f_s4", f4, 8'h33);
        repeat (12) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
